// File: rtl/issue_pkg.sv
// Shared types and constants for the issue controller: FSM states, ARM condition
// codes, NZCV bit positions and instruction-field positions.
package issue_pkg;

    typedef enum logic [1:0] {IDLE, CHECK, WAIT_FLAGS, ISSUE} issState_t;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int S_BIT    = 20;
    localparam int CLASS_HI = 27;
    localparam int CLASS_LO = 26;

    // Data-processing class with the S bit set writes NZCV.
    function automatic logic setsFlags(input logic [31:0] instr);
        return (instr[CLASS_HI:CLASS_LO] == 2'b00) && instr[S_BIT];
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator against an NZCV nibble.
module cond_eval
    import issue_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;
    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller: replay/fetch arbitration, condition squash and flag-hazard tracking.
// Define ISSUE_CTRL_PERF_EN to add issued/squashed/stall performance counters.
module issue_ctrl
    import issue_pkg::*;
#(
    parameter int MAX_PEND = 3,
    parameter int PEND_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fe_valid,
    output logic              fe_ready,
    input  logic [31:0]       fe_instr,
    input  logic              rp_valid,
    output logic              rp_ready,
    input  logic [31:0]       rp_instr,
    input  logic [3:0]        cpsr_flags,
    input  logic              flags_wb,
    output logic              iss_valid,
    input  logic              iss_ready,
    output logic [31:0]       iss_instr,
    output logic              squash,
    output logic [PEND_W-1:0] pending_cnt
`ifdef ISSUE_CTRL_PERF_EN
    ,
    output logic [31:0]       issued_cnt,
    output logic [31:0]       squashed_cnt,
    output logic [31:0]       stall_cyc
`endif
);

    issState_t         state, nextState;
    logic [31:0]       capInstr;
    logic [PEND_W-1:0] pendCnt;
    logic              squashQ, squashNext, stallNow;
    logic              condPass, accept, issHs, incPend;
    logic              isCond, pendZero, limitHold;

    cond_eval uCondEval (
        .cond (capInstr[31:28]),
        .nzcv (cpsr_flags),
        .pass (condPass)
    );

    assign rp_ready    = (state == IDLE) && !rst;
    assign fe_ready    = (state == IDLE) && !rp_valid && !rst;
    assign accept      = (rp_valid && rp_ready) || (fe_valid && fe_ready);
    assign iss_valid   = (state == ISSUE);
    assign iss_instr   = capInstr;
    assign squash      = squashQ;
    assign pending_cnt = pendCnt;

    assign issHs     = (state == ISSUE) && iss_ready;
    assign incPend   = issHs && setsFlags(capInstr);
    assign isCond    = capInstr[31:28] != COND_AL;
    assign pendZero  = (pendCnt == '0);
    assign limitHold = setsFlags(capInstr) && (pendCnt == PEND_W'(MAX_PEND));

    always_comb begin
        nextState  = state;
        squashNext = 1'b0;
        stallNow   = 1'b0;
        case (state)
            IDLE: if (accept) nextState = CHECK;
            CHECK: begin
                // Conditional instructions never see flags with setters in flight.
                if (isCond && !pendZero) begin
                    nextState = WAIT_FLAGS;
                end else if (limitHold) begin
                    stallNow = 1'b1;
                end else if (condPass) begin
                    nextState = ISSUE;
                end else begin
                    squashNext = 1'b1;
                    nextState  = IDLE;
                end
            end
            WAIT_FLAGS: begin
                stallNow = 1'b1;
                if (pendZero) nextState = CHECK;
            end
            ISSUE: if (iss_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            capInstr <= '0;
            pendCnt  <= '0;
            squashQ  <= 1'b0;
        end else begin
            state   <= nextState;
            squashQ <= squashNext;
            if ((state == IDLE) && accept)
                capInstr <= rp_valid ? rp_instr : fe_instr;
            // A writeback coinciding with an increment cancels it; no underflow.
            case ({incPend, flags_wb})
                2'b10:   pendCnt <= pendCnt + 1'b1;
                2'b01:   if (!pendZero) pendCnt <= pendCnt - 1'b1;
                default: pendCnt <= pendCnt;
            endcase
        end
    end

`ifdef ISSUE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_cnt   <= '0;
            squashed_cnt <= '0;
            stall_cyc    <= '0;
        end else begin
            if (issHs)    issued_cnt   <= issued_cnt + 1;
            if (squashQ)  squashed_cnt <= squashed_cnt + 1;
            if (stallNow) stall_cyc    <= stall_cyc + 1;
        end
    end
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: priority, squash, flag hazard, saturation,
// backpressure and mid-issue reset. Inputs change after posedge, outputs sampled at negedge.
module tb_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fe_valid, fe_ready, rp_valid, rp_ready;
    logic [31:0] fe_instr, rp_instr, iss_instr;
    logic [3:0]  cpsr_flags;
    logic        flags_wb, iss_valid, iss_ready, squash;
    logic [1:0]  pending_cnt;
`ifdef ISSUE_CTRL_PERF_EN
    logic [31:0] issued_cnt, squashed_cnt, stall_cyc;
`endif

    int errCnt = 0;
    int chkCnt = 0;

    issue_ctrl #(.MAX_PEND(3), .PEND_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .fe_valid    (fe_valid),
        .fe_ready    (fe_ready),
        .fe_instr    (fe_instr),
        .rp_valid    (rp_valid),
        .rp_ready    (rp_ready),
        .rp_instr    (rp_instr),
        .cpsr_flags  (cpsr_flags),
        .flags_wb    (flags_wb),
        .iss_valid   (iss_valid),
        .iss_ready   (iss_ready),
        .iss_instr   (iss_instr),
        .squash      (squash),
        .pending_cnt (pending_cnt)
`ifdef ISSUE_CTRL_PERF_EN
        ,
        .issued_cnt  (issued_cnt),
        .squashed_cnt(squashed_cnt),
        .stall_cyc   (stall_cyc)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // cond, NZCV, expected pass
    logic [3:0] vCond [12] = '{4'h8, 4'h8, 4'hA, 4'hB, 4'hC, 4'hD,
                               4'h9, 4'hF, 4'h4, 4'h5, 4'h6, 4'h3};
    logic [3:0] vFlag [12] = '{4'b0010, 4'b0110, 4'b1001, 4'b1001, 4'b0000, 4'b0000,
                               4'b0100, 4'b1111, 4'b1000, 4'b1000, 4'b0001, 4'b0010};
    logic       vPass [12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                               1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        rst = 1'b1; fe_valid = 1'b0; rp_valid = 1'b0; fe_instr = '0; rp_instr = '0;
        cpsr_flags = '0; flags_wb = 1'b0; iss_ready = 1'b0;

        // Reset state
        step(); step();
        @(negedge clk);
        chk("rstRpReady", rp_ready, 1'b0);
        chk("rstFeReady", fe_ready, 1'b0);
        chk("rstIssValid", iss_valid, 1'b0);
        chk("rstIssInstr", iss_instr, 32'h0);
        chk("rstSquash", squash, 1'b0);
        chk("rstPend", pending_cnt, 2'd0);

        // Replay beats fetch; each issues 2 cycles after its handshake
        step();
        rst = 1'b0; iss_ready = 1'b1;
        rp_valid = 1'b1; rp_instr = 32'hE1A00001;
        fe_valid = 1'b1; fe_instr = 32'hE1A00002;
        @(negedge clk);
        chk("prioRpReady", rp_ready, 1'b1);
        chk("prioFeBlocked", fe_ready, 1'b0);
        step(); rp_valid = 1'b0;
        @(negedge clk);
        chk("rpLatency1", iss_valid, 1'b0);
        step();
        @(negedge clk);
        chk("rpIssValid", iss_valid, 1'b1);
        chk("rpIssInstr", iss_instr, 32'hE1A00001);
        step();
        @(negedge clk);
        chk("rpDone", iss_valid, 1'b0);
        chk("feReadyNow", fe_ready, 1'b1);
        step(); fe_valid = 1'b0;
        step();
        @(negedge clk);
        chk("feIssValid", iss_valid, 1'b1);
        chk("feIssInstr", iss_instr, 32'hE1A00002);
        step();

        // EQ with Z=0 squashes; with Z=1 issues
        cpsr_flags = 4'b0000; fe_valid = 1'b1; fe_instr = 32'h01A00001;
        step(); fe_valid = 1'b0;
        @(negedge clk);
        chk("sqNotYet", squash, 1'b0);
        step();
        @(negedge clk);
        chk("sqPulse", squash, 1'b1);
        chk("sqNoIssue", iss_valid, 1'b0);
        step();
        @(negedge clk);
        chk("sqOneCycle", squash, 1'b0);
        chk("sqNoIssue2", iss_valid, 1'b0);
        cpsr_flags = 4'b0100; fe_valid = 1'b1;
        step(); fe_valid = 1'b0;
        step();
        @(negedge clk);
        chk("eqIssValid", iss_valid, 1'b1);
        chk("eqIssInstr", iss_instr, 32'h01A00001);
        chk("eqNoSquash", squash, 1'b0);
        step();

        // CMP then NE: NE waits for the flag writeback
        cpsr_flags = 4'b0000; fe_valid = 1'b1; fe_instr = 32'hE1500001;
        step(); fe_instr = 32'h11A00002;
        step();
        @(negedge clk);
        chk("cmpIssInstr", iss_instr, 32'hE1500001);
        step();
        @(negedge clk);
        chk("pendOne", pending_cnt, 2'd1);
        step(); fe_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("hazHoldValid", iss_valid, 1'b0);
            chk("hazHoldPend", pending_cnt, 2'd1);
        end
        flags_wb = 1'b1;
        step(); flags_wb = 1'b0;
        @(negedge clk);
        chk("hazPendZero", pending_cnt, 2'd0);
        chk("hazStillWait", iss_valid, 1'b0);
        step();
        @(negedge clk);
        chk("hazEvalCycle", iss_valid, 1'b0);
        step();
        @(negedge clk);
        chk("hazIssValid", iss_valid, 1'b1);
        chk("hazIssInstr", iss_instr, 32'h11A00002);
        step();

        // Condition table sweep
        for (int k = 0; k < 12; k++) begin
            cpsr_flags = vFlag[k];
            fe_valid = 1'b1; fe_instr = {vCond[k], 28'h1A00003};
            step(); fe_valid = 1'b0;
            step();
            @(negedge clk);
            chk($sformatf("condIss%0d", k), iss_valid, vPass[k]);
            chk($sformatf("condSq%0d", k), squash, !vPass[k]);
            if (vPass[k]) step();
            else #1;
        end
        step();

        // Three setters saturate; fourth held in CHECK
        fe_valid = 1'b1; fe_instr = 32'hE1500001;
        for (int k = 0; k < 3; k++) begin
            step(); step(); step();
        end
        @(negedge clk);
        chk("satPend3", pending_cnt, 2'd3);
        step(); fe_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("satHoldValid", iss_valid, 1'b0);
            chk("satHoldFeReady", fe_ready, 1'b0);
            chk("satHoldPend", pending_cnt, 2'd3);
        end
        flags_wb = 1'b1;
        step(); flags_wb = 1'b0;
        @(negedge clk);
        chk("satPend2", pending_cnt, 2'd2);
        chk("satStillHeld", iss_valid, 1'b0);
        step();
        @(negedge clk);
        chk("satIssValid", iss_valid, 1'b1);
        flags_wb = 1'b1;
        step(); flags_wb = 1'b0;
        @(negedge clk);
        chk("simulIncWb", pending_cnt, 2'd2);
        chk("simulDone", iss_valid, 1'b0);
        flags_wb = 1'b1;
        step(); step();
        @(negedge clk);
        chk("drainZero", pending_cnt, 2'd0);
        step(); flags_wb = 1'b0;
        @(negedge clk);
        chk("noUnderflow", pending_cnt, 2'd0);

        // Backpressure with a setter pending, then reset mid-ISSUE
        step();
        fe_valid = 1'b1; fe_instr = 32'hE1500001; iss_ready = 1'b1;
        step(); step(); step();
        fe_instr = 32'hE1A00005; iss_ready = 1'b0;
        step(); fe_valid = 1'b0;
        step();
        @(negedge clk);
        chk("bpPendOne", pending_cnt, 2'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bpValid", iss_valid, 1'b1);
            chk("bpInstr", iss_instr, 32'hE1A00005);
            step();
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rstRpLow", rp_ready, 1'b0);
        step();
        @(negedge clk);
        chk("midRstValid", iss_valid, 1'b0);
        chk("midRstInstr", iss_instr, 32'h0);
        chk("midRstSquash", squash, 1'b0);
        chk("midRstPend", pending_cnt, 2'd0);
        chk("midRstFeReady", fe_ready, 1'b0);
        step(); rst = 1'b0; iss_ready = 1'b1;
        @(negedge clk);
        chk("postRstSquash", squash, 1'b0);
        chk("postRstValid", iss_valid, 1'b0);
        chk("postRstRpReady", rp_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Clocked issue controller that feeds the instruction issue datapath.
- Arbitrates between two instruction requesters: fetch and replay.
- Evaluates the full ARM condition field against CPSR NZCV, squashes instructions whose condition fails, and forwards passing instructions through a valid/ready issue port.
- Tracks in-flight flag-setting instructions. A conditional instruction is never evaluated against stale flags.

Parameters:
- MAX_PEND, 3: maximum number of issued flag-setting instructions awaiting flag writeback.
- PEND_W, 2: width of the pending counter. Constraint: MAX_PEND <= 2**PEND_W - 1.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- fe_valid  in  1  fetch requester has an instruction
- fe_ready  out  1  fetch instruction accepted this cycle when fe_valid is also high
- fe_instr  in  32  fetch instruction word
- rp_valid  in  1  replay requester has an instruction
- rp_ready  out  1  replay instruction accepted this cycle when rp_valid is also high
- rp_instr  in  32  replay instruction word
- cpsr_flags  in  4  {N,Z,C,V}; N is bit 3
- flags_wb  in  1  single-cycle pulse: one flag-setting instruction has written CPSR
- iss_valid  out  1  issue port holds a condition-passed instruction
- iss_ready  in  1  downstream accepts
- iss_instr  out  32  issued instruction word
- squash  out  1  single-cycle pulse: captured instruction dropped because its condition failed
- pending_cnt  out  PEND_W  outstanding flag setters

Behaviour:
- Reset values: state IDLE; fe_ready=0 and rp_ready=0 during the reset cycle; iss_valid=0; iss_instr=0; squash=0; pending_cnt=0; capture register=0. Reset mid-operation drops any captured or issuing instruction without a squash pulse.
- The state machine has four states: IDLE, CHECK, WAIT_FLAGS and ISSUE.
- IDLE, ready signals:
  - rp_ready = (state==IDLE) && !rst.
  - fe_ready = (state==IDLE) && !rp_valid && !rst.
  - Replay has fixed priority over fetch.
- IDLE, capture: on a handshake, latch the instruction word and go to CHECK. With no valid request, stay in IDLE.
- Classification:
  - cond = instr[31:28].
  - The instruction sets flags when instr[27:26]==2'b00 and instr[20]==1.
- CHECK and WAIT_FLAGS, conditional instructions (cond != 4'b1110):
  - If pending_cnt != 0, go to WAIT_FLAGS.
  - WAIT_FLAGS returns to CHECK in the cycle after pending_cnt reaches 0.
- CHECK, flag-setter limit: if the instruction sets flags and pending_cnt == MAX_PEND, stay in CHECK.
- CHECK, evaluation:
  - Condition pass: go to ISSUE; iss_valid=1 in the next cycle.
  - Condition fail: squash=1 for one cycle, then IDLE.
  - cond 4'b1111 (NV) always fails.
- ISSUE:
  - iss_valid and iss_instr are held stable until iss_ready is high; the handshake completes in that cycle.
  - Next state is IDLE.
  - If the issued instruction sets flags, pending_cnt increments on the handshake.
- Latency: with no flag stall and iss_ready tied high, iss_valid rises 2 cycles after the input handshake. Maximum throughput is one instruction per 3 cycles.
- Pending counter rules:
  - Increment and flags_wb in the same cycle: net unchanged.
  - flags_wb with pending_cnt==0 is ignored; there is no underflow.
  - The counter never exceeds MAX_PEND.
- Condition evaluation:
  - The condition is sampled from cpsr_flags combinationally in the CHECK cycle.
  - The table follows ARM: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; NV 0.

Optional Feature:
- Macro: ISSUE_CTRL_PERF_EN.
- Defined: adds three outputs, each in 32 and reset to 0, with free-running wrap-around on overflow:
  - issued_cnt increments on each iss handshake.
  - squashed_cnt increments on each squash pulse.
  - stall_cyc increments on each cycle spent in WAIT_FLAGS, or in CHECK held by the MAX_PEND limit.
- Undefined: the three ports and counters are absent. Functional behaviour is otherwise identical.

Decomposition:
- Shared package issue_pkg:
  - state encoding type for the four states;
  - the 16 condition-code constants (COND_EQ through COND_NV);
  - NZCV bit index constants;
  - localparams for the S-bit position (20) and class field [27:26].
- One sub-module, cond_eval: purely combinational, taking cond[3:0] and nzcv[3:0] and producing pass. It is instantiated once and reused by the verification model.

Test Plan:
- Priority and basic issue:
  - Stimulus: fe_valid and rp_valid both asserted; rp_instr=32'hE1A00001; fe_instr=32'hE1A00002; iss_ready=1.
  - Response: replay issued first, 2 cycles after its handshake; the fetch instruction follows; iss_instr matches each word.
- Condition squash:
  - Stimulus: cpsr_flags=4'b0000; instr 32'h01A00001 (EQ).
  - Response: one-cycle squash pulse; iss_valid stays 0. Repeating with Z=1 (4'b0100) issues the instruction.
- Flag hazard:
  - Stimulus: issue 32'hE1500001 (CMP, sets flags), then 32'h11A00002 (NE).
  - Response: pending_cnt=1; the NE instruction waits in WAIT_FLAGS until the flags_wb pulse; it is evaluated in the cycle after pending_cnt returns to 0.
- Saturation and simultaneous events:
  - Stimulus: issue three flag setters with MAX_PEND=3 and no flags_wb, then issue a fourth.
  - Response: the fourth is held in CHECK. A flags_wb arriving in the same cycle as an issue handshake leaves pending_cnt unchanged. A spurious flags_wb at pending_cnt=0 leaves it at 0.
- Backpressure and reset:
  - Stimulus: iss_ready=0 for 5 cycles; assert rst mid-ISSUE.
  - Response: iss_instr stays stable while stalled. On the cycle after reset, all outputs are at their reset values, pending_cnt=0 and no squash pulse occurs.
